imem_rd_arbiter: RTL and testbench

Two-master AXI4-Lite read-channel arbiter that shares the single read port of `imem_axi_lite` between the CPU instruction fetch (master 0) and a secondary reader such as a debug or boot-loader port (master 1). It accepts one read at a time, forwards it to the memory, and routes the read data back to the requester that issued it. Arbitration is round-robin. Only one transaction is outstanding at any time. The block sits between the masters and the memory's `i_axi_ar*`/`o_axi_r*` port.

---
 rtl/imem_rd_arbiter.sv | 112 +++++++++++
 tb/tb_imem_rd_arbiter.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/imem_rd_arbiter.sv
// Two-master AXI4-Lite read arbiter in front of the instruction memory read port.
// Round-robin between CPU fetch (m0) and a secondary reader (m1); one transaction in flight.
module imem_rd_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [ADDR_WIDTH-1:0] i_m0_araddr,
  input  logic                  i_m0_arvalid,
  output logic                  o_m0_arready,
  output logic [DATA_WIDTH-1:0] o_m0_rdata,
  output logic                  o_m0_rvalid,
  input  logic                  i_m0_rready,
  input  logic [ADDR_WIDTH-1:0] i_m1_araddr,
  input  logic                  i_m1_arvalid,
  output logic                  o_m1_arready,
  output logic [DATA_WIDTH-1:0] o_m1_rdata,
  output logic                  o_m1_rvalid,
  input  logic                  i_m1_rready,
  output logic [ADDR_WIDTH-1:0] o_axi_araddr,
  output logic                  o_axi_arvalid,
  input  logic                  i_axi_arready,
  input  logic [DATA_WIDTH-1:0] i_axi_rdata,
  input  logic                  i_axi_rvalid,
  output logic                  o_axi_rready,
  output logic [1:0]            o_grant,
  output logic                  o_busy
);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA} state_t;

  state_t                  state_q, state_d;
  logic [1:0]              grant_q, grant_d;
  logic                    last_q, last_d;     // 1: master 1 was served last
  logic [ADDR_WIDTH-1:0]   araddr_q, araddr_d;
  logic                    arvalid_q, arvalid_d;
  logic                    win0, win1;
  logic                    sel_rready;
  logic                    r_hs;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      grant_q   <= 2'b00;
      last_q    <= 1'b1;
      araddr_q  <= '0;
      arvalid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
      araddr_q  <= araddr_d;
      arvalid_q <= arvalid_d;
    end
  end

  always_comb begin
    win0       = 1'b0;
    win1       = 1'b0;
    state_d    = state_q;
    grant_d    = grant_q;
    last_d     = last_q;
    araddr_d   = araddr_q;
    arvalid_d  = arvalid_q;
    if (state_q == S_IDLE) begin
      win0 = i_m0_arvalid & (~i_m1_arvalid | last_q);
      win1 = i_m1_arvalid & (~i_m0_arvalid | ~last_q);
    end
    sel_rready   = grant_q[1] ? i_m1_rready : i_m0_rready;
    o_axi_rready = (state_q == S_DATA) & sel_rready;
    r_hs         = i_axi_rvalid & o_axi_rready;

    case (state_q)
      S_IDLE: begin
        if (win0 | win1) begin
          araddr_d  = win1 ? i_m1_araddr : i_m0_araddr;
          grant_d   = {win1, win0};
          arvalid_d = 1'b1;
          state_d   = S_ADDR;
        end
      end
      S_ADDR: begin
        if (i_axi_arready) begin
          arvalid_d = 1'b0;
          state_d   = S_DATA;
        end
      end
      S_DATA: begin
        if (r_hs) begin
          last_d  = grant_q[1];
          grant_d = 2'b00;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // arready is combinational, so it is also masked while reset is held
  assign o_m0_arready  = resetn & win0;
  assign o_m1_arready  = resetn & win1;
  assign o_m0_rvalid   = (state_q == S_DATA) & grant_q[0] & i_axi_rvalid;
  assign o_m1_rvalid   = (state_q == S_DATA) & grant_q[1] & i_axi_rvalid;
  assign o_m0_rdata    = i_axi_rdata;
  assign o_m1_rdata    = i_axi_rdata;
  assign o_axi_araddr  = araddr_q;
  assign o_axi_arvalid = arvalid_q;
  assign o_grant       = grant_q;
  assign o_busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_imem_rd_arbiter.sv
// Directed, table-driven bench for imem_rd_arbiter; the bench plays the memory slave.
module tb_imem_rd_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic [31:0] i_m0_araddr, i_m1_araddr, o_m0_rdata, o_m1_rdata;
  logic        i_m0_arvalid, o_m0_arready, o_m0_rvalid, i_m0_rready;
  logic        i_m1_arvalid, o_m1_arready, o_m1_rvalid, i_m1_rready;
  logic [31:0] o_axi_araddr, i_axi_rdata;
  logic        o_axi_arvalid, i_axi_arready, i_axi_rvalid, o_axi_rready;
  logic [1:0]  o_grant;
  logic        o_busy;

  int n_cmp = 0;
  int n_err = 0;

  imem_rd_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .resetn(resetn),
    .i_m0_araddr(i_m0_araddr), .i_m0_arvalid(i_m0_arvalid), .o_m0_arready(o_m0_arready),
    .o_m0_rdata(o_m0_rdata), .o_m0_rvalid(o_m0_rvalid), .i_m0_rready(i_m0_rready),
    .i_m1_araddr(i_m1_araddr), .i_m1_arvalid(i_m1_arvalid), .o_m1_arready(o_m1_arready),
    .o_m1_rdata(o_m1_rdata), .o_m1_rvalid(o_m1_rvalid), .i_m1_rready(i_m1_rready),
    .o_axi_araddr(o_axi_araddr), .o_axi_arvalid(o_axi_arvalid), .i_axi_arready(i_axi_arready),
    .i_axi_rdata(i_axi_rdata), .i_axi_rvalid(i_axi_rvalid), .o_axi_rready(o_axi_rready),
    .o_grant(o_grant), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        r0;
    logic [31:0] a0;
    logic        r1;
    logic [31:0] a1;
    logic        w;     // expected winner: 0 = m0, 1 = m1
    int          ar;    // cycles before memory arready
    int          rr;    // cycles the winner holds rready low while rvalid is up
    logic        late;  // loser raises arvalid after the winner is accepted
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] word(input logic [31:0] a);
    return 32'hC0DE_0000 ^ a;
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_arvalid"}, o_axi_arvalid, 0);
    chk({tag, "_araddr"},  o_axi_araddr, 0);
    chk({tag, "_rready"},  o_axi_rready, 0);
    chk({tag, "_arready"}, {o_m1_arready, o_m0_arready}, 0);
    chk({tag, "_rvalid"},  {o_m1_rvalid, o_m0_rvalid}, 0);
    chk({tag, "_grant"},   o_grant, 0);
    chk({tag, "_busy"},    o_busy, 0);
  endtask

  // Entered just after a rising edge with the DUT in IDLE; returns the same way.
  task automatic run_txn(input vec_t v);
    logic [1:0]  g;
    logic [31:0] a;
    g = v.w ? 2'b10 : 2'b01;
    a = v.w ? v.a1 : v.a0;
    i_m0_arvalid = v.r0; i_m0_araddr = v.a0;
    i_m1_arvalid = v.r1; i_m1_araddr = v.a1;
    @(negedge clk);
    chk("idle_grant", o_grant, 0);
    chk("idle_busy", o_busy, 0);
    chk("idle_arready0", o_m0_arready, !v.w);
    chk("idle_arready1", o_m1_arready, v.w);
    @(posedge clk); #1;
    if (v.w) i_m1_arvalid = 1'b0; else i_m0_arvalid = 1'b0;
    if (v.late) begin
      if (v.w) i_m0_arvalid = 1'b1; else i_m1_arvalid = 1'b1;
    end
    i_m0_rready = 1'b1; i_m1_rready = 1'b1;
    for (int k = 0; k < v.ar; k++) begin
      i_axi_rvalid = 1'b1; i_axi_rdata = 32'hDEAD_BEEF;
      @(negedge clk);
      chk("addr_arvalid", o_axi_arvalid, 1);
      chk("addr_araddr", o_axi_araddr, a);
      chk("addr_grant", o_grant, g);
      chk("addr_rvalid_blocked", {o_m1_rvalid, o_m0_rvalid}, 0);
      chk("addr_rready", o_axi_rready, 0);
      chk("addr_arready", {o_m1_arready, o_m0_arready}, 0);
      @(posedge clk); #1;
    end
    i_axi_rvalid = 1'b0; i_axi_arready = 1'b1;
    @(negedge clk);
    chk("ar_arvalid", o_axi_arvalid, 1);
    chk("ar_araddr", o_axi_araddr, a);
    chk("ar_busy", o_busy, 1);
    chk("ar_arready", {o_m1_arready, o_m0_arready}, 0);
    @(posedge clk); #1;
    i_axi_arready = 1'b0;
    i_axi_rvalid = 1'b1; i_axi_rdata = word(a);
    for (int k = 0; k <= v.rr; k++) begin
      if (v.w) begin i_m1_rready = (k == v.rr); i_m0_rready = 1'b1; end
      else     begin i_m0_rready = (k == v.rr); i_m1_rready = 1'b1; end
      @(negedge clk);
      chk("data_arvalid", o_axi_arvalid, 0);
      chk("data_rready", o_axi_rready, (k == v.rr));
      chk("data_rvalid", {o_m1_rvalid, o_m0_rvalid}, g);
      chk("data_rdata", v.w ? o_m1_rdata : o_m0_rdata, word(a));
      chk("data_grant", o_grant, g);
      chk("data_arready", {o_m1_arready, o_m0_arready}, 0);
      @(posedge clk); #1;
    end
    i_axi_rvalid = 1'b0; i_m0_rready = 1'b0; i_m1_rready = 1'b0;
  endtask

  initial begin
    vecs[0] = '{1'b1, 32'h4,  1'b1, 32'h8,  1'b0, 0, 0, 1'b0}; // first contention: m0
    vecs[1] = '{1'b1, 32'h4,  1'b1, 32'h8,  1'b1, 0, 0, 1'b0}; // repeat: m1
    vecs[2] = '{1'b1, 32'h0,  1'b0, 32'h0,  1'b0, 0, 0, 1'b0}; // single m0 read
    vecs[3] = '{1'b0, 32'h0,  1'b1, 32'h20, 1'b1, 3, 0, 1'b0}; // slow slave
    vecs[4] = '{1'b0, 32'h40, 1'b1, 32'h24, 1'b1, 0, 5, 1'b1}; // backpressure, m0 waits
    vecs[5] = '{1'b1, 32'h40, 1'b0, 32'h0,  1'b0, 0, 0, 1'b0}; // m0 served afterwards
    for (int i = 0; i < 8; i++)
      vecs[6+i] = '{1'b1, 32'h100 + 32'(i*8), 1'b1, 32'h200 + 32'(i*8), (i % 2 == 0), 0, 0, 1'b0};

    resetn = 1'b0;
    i_m0_arvalid = 0; i_m0_araddr = 0; i_m0_rready = 0;
    i_m1_arvalid = 0; i_m1_araddr = 0; i_m1_rready = 0;
    i_axi_arready = 0; i_axi_rvalid = 0; i_axi_rdata = 0;
    #12;
    chk_all_zero("reset");
    @(negedge clk); resetn = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 14; i++) run_txn(vecs[i]);
    i_m0_arvalid = 0; i_m1_arvalid = 0;
    @(negedge clk);
    chk("end_grant", o_grant, 0);
    chk("end_busy", o_busy, 0);

    // Reset while a response is pending in DATA
    @(posedge clk); #1;
    i_m0_arvalid = 1'b1; i_m0_araddr = 32'h30;
    @(posedge clk); #1;
    i_m0_arvalid = 1'b0; i_axi_arready = 1'b1;
    @(posedge clk); #1;
    i_axi_arready = 1'b0; i_axi_rvalid = 1'b1; i_axi_rdata = word(32'h30); i_m0_rready = 1'b0;
    @(negedge clk);
    chk("pre_rst_rvalid", o_m0_rvalid, 1);
    chk("pre_rst_busy", o_busy, 1);
    #2;
    i_m1_arvalid = 1'b1; i_m1_araddr = 32'h50;
    resetn = 1'b0;
    #1;
    chk("midrst_arvalid", o_axi_arvalid, 0);
    chk("midrst_araddr", o_axi_araddr, 0);
    chk("midrst_arready", {o_m1_arready, o_m0_arready}, 0);
    chk("midrst_rvalid", {o_m1_rvalid, o_m0_rvalid}, 0);
    chk("midrst_grant", o_grant, 0);
    chk("midrst_busy", o_busy, 0);
    i_m1_arvalid = 1'b0; i_axi_rvalid = 1'b0;
    @(negedge clk); resetn = 1'b1;
    @(posedge clk); #1;
    run_txn('{1'b1, 32'h0, 1'b0, 32'h0, 1'b0, 0, 0, 1'b0});
    @(negedge clk);
    chk("post_rst_grant", o_grant, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
